// File: rtl/aes_ip_top.sv
// AHB-Lite slave around a byte-serial iterative AES-128 encryptor (single shared S-box).
// Define AES_BIST_EN to build in the BIST engine (LFSR stimulus, MISR signature, CTRL1).
module aes_ip_top #(
    parameter int unsigned  BIST_COUNT = 16,
    parameter logic [127:0] LFSR_SEED  = 128'h0123456789ABCDEF_FEDCBA9876543210
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP
);

    typedef enum logic [2:0] {C_IDLE, C_LOAD, C_SUB, C_KEY, C_MIX, C_OUT} core_state_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Inverse as x^254 = x^2 * x^4 * ... * x^128, then the FIPS-197 affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq, inv;
        sq  = x;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    // State byte i lives at [127-8i -: 8]; row = i%4, column = i/4.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    logic         dvalid_q, dwrite_q;
    logic [3:0]   daddr_q;
    logic [31:0]  hrdata_q, rd_data;
    logic         start_pending_q, busy_q, done_q;
    logic [127:0] key_q, pt_q, ct_q;

    core_state_e  cstate_q;
    logic [127:0] st_q, rk_q, op_key_q, op_pt_q;
    logic [31:0]  kt_q;
    logic [7:0]   rcon_q;
    logic [3:0]   cnt_q, rnd_q;

    logic         addr_ph, wr_en, norm_go, core_go, core_abort, core_done;
    logic [127:0] go_key, go_pt;
    logic         bist_en, bist_run, bist_start, bist_next, bist_final, bist_abort;
    logic [127:0] bist_key, bist_pt, misr_d;
    logic [7:0]   sbox_in, sbox_out;
    logic [31:0]  w0_d, w1_d, w2_d, w3_d;
    logic [127:0] rk_d, sr_d, st_mix_d;
    logic         unused_bits;

    assign unused_bits = ^{HSIZE, HBURST, HADDR[31:6], HADDR[1:0]};
    assign HREADYOUT   = 1'b1;
    assign HRESP       = 1'b0;
    assign HRDATA      = hrdata_q;

    assign addr_ph    = HSEL & HREADY & HTRANS[1];
    assign wr_en      = dvalid_q & dwrite_q;
    assign norm_go    = wr_en && (daddr_q == 4'd11) && start_pending_q && !busy_q && !bist_en;
    assign core_go    = norm_go | bist_start | bist_next;
    assign core_abort = bist_abort;
    assign core_done  = (cstate_q == C_OUT);
    // A PT3 launch takes the word being written this cycle directly from the bus.
    assign go_key     = norm_go ? key_q : bist_key;
    assign go_pt      = norm_go ? {HWDATA, pt_q[95:0]} : bist_pt;

`ifdef AES_BIST_EN
    logic         bist_en_q, bist_run_q, bist_last;
    logic [127:0] lfsr_q, lfsr_d, misr_q, bist_src;
    logic [15:0]  bist_cnt_q;

    assign lfsr_d     = {lfsr_q[126:0], lfsr_q[127] ^ lfsr_q[6] ^ lfsr_q[1] ^ lfsr_q[0]};
    assign bist_en    = bist_en_q;
    assign bist_run   = bist_run_q;
    assign bist_start = wr_en && (daddr_q == 4'd1) && HWDATA[0] && !bist_en_q;
    assign bist_abort = wr_en && (daddr_q == 4'd1) && !HWDATA[0] && bist_run_q;
    assign bist_last  = (bist_cnt_q == 16'(BIST_COUNT - 1));
    assign bist_final = core_done && bist_run_q && bist_last;
    assign bist_next  = core_done && bist_run_q && !bist_last;
    // Encryption n uses the seed stepped n times: key = LFSR, plaintext = LFSR halves swapped.
    assign bist_src   = bist_start ? LFSR_SEED : lfsr_d;
    assign bist_key   = bist_src;
    assign bist_pt    = {bist_src[63:0], bist_src[127:64]};
    assign misr_d     = {misr_q[126:0], misr_q[127]} ^ st_q;

    always_ff @(posedge HCLK or posedge HRESETn) begin
        if (HRESETn) begin
            bist_en_q  <= 1'b0;
            bist_run_q <= 1'b0;
            lfsr_q     <= LFSR_SEED;
            misr_q     <= '0;
            bist_cnt_q <= '0;
        end else begin
            if (core_done && bist_run_q) begin
                misr_q     <= misr_d;
                lfsr_q     <= lfsr_d;
                bist_cnt_q <= bist_cnt_q + 16'd1;
                if (bist_last) bist_run_q <= 1'b0;
            end
            if (wr_en && (daddr_q == 4'd1)) bist_en_q <= HWDATA[0];
            if (bist_start) begin
                misr_q     <= '0;
                lfsr_q     <= LFSR_SEED;
                bist_cnt_q <= '0;
                bist_run_q <= 1'b1;
            end
            if (bist_abort) bist_run_q <= 1'b0;
        end
    end
`else
    logic [127:0] unused_cfg;
    assign unused_cfg = LFSR_SEED ^ 128'(BIST_COUNT);
    assign bist_en    = 1'b0;
    assign bist_run   = 1'b0;
    assign bist_start = 1'b0;
    assign bist_next  = 1'b0;
    assign bist_final = 1'b0;
    assign bist_abort = 1'b0;
    assign bist_key   = '0;
    assign bist_pt    = '0;
    assign misr_d     = '0;
`endif

    always_comb begin
        rd_data = 32'h0;
        case (HADDR[5:2])
            4'd0:                      rd_data = {31'h0, start_pending_q};
            4'd1:                      rd_data = {31'h0, bist_en};
            4'd2:                      rd_data = {30'h0, busy_q, done_q};
            4'd4, 4'd5, 4'd6, 4'd7:    rd_data = key_q[{HADDR[3:2], 5'd0} +: 32];
            4'd8, 4'd9, 4'd10, 4'd11:  rd_data = pt_q[{HADDR[3:2], 5'd0} +: 32];
            4'd12, 4'd13, 4'd14, 4'd15: rd_data = ct_q[{HADDR[3:2], 5'd0} +: 32];
            default:                   rd_data = 32'h0;
        endcase
    end

    // Bus front end and software-visible registers; later statements take priority.
    always_ff @(posedge HCLK or posedge HRESETn) begin
        if (HRESETn) begin
            dvalid_q        <= 1'b0;
            dwrite_q        <= 1'b0;
            daddr_q         <= '0;
            hrdata_q        <= '0;
            start_pending_q <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            key_q           <= '0;
            pt_q            <= '0;
            ct_q            <= '0;
        end else begin
            dvalid_q <= addr_ph;
            dwrite_q <= HWRITE;
            daddr_q  <= HADDR[5:2];
            if (addr_ph && !HWRITE) hrdata_q <= rd_data;
            if (core_done && !bist_run) begin
                ct_q   <= st_q;
                busy_q <= 1'b0;
                done_q <= 1'b1;
            end
            if (bist_final) begin
                ct_q   <= misr_d;
                busy_q <= 1'b0;
                done_q <= 1'b1;
            end
            if (wr_en) begin
                case (daddr_q)
                    4'd0: if (!bist_en) begin
                        start_pending_q <= HWDATA[0];
                        if (HWDATA[0]) done_q <= 1'b0;
                    end
                    4'd4, 4'd5, 4'd6, 4'd7:   key_q[{daddr_q[1:0], 5'd0} +: 32] <= HWDATA;
                    4'd8, 4'd9, 4'd10, 4'd11: pt_q[{daddr_q[1:0], 5'd0} +: 32]  <= HWDATA;
                    default: ;
                endcase
            end
            if (norm_go) begin
                start_pending_q <= 1'b0;
                busy_q          <= 1'b1;
                done_q          <= 1'b0;
            end
            if (bist_start) begin
                busy_q <= 1'b1;
                done_q <= 1'b0;
            end
            if (bist_abort) busy_q <= 1'b0;
        end
    end

    // The single S-box serves the state bytes in C_SUB and RotWord(w3) bytes in C_KEY.
    always_comb begin
        sbox_in = st_q[127:120];
        if (cstate_q == C_KEY) begin
            case (cnt_q[1:0])
                2'd0:    sbox_in = rk_q[23:16];
                2'd1:    sbox_in = rk_q[15:8];
                2'd2:    sbox_in = rk_q[7:0];
                default: sbox_in = rk_q[31:24];
            endcase
        end
    end

    assign sbox_out = sbox(sbox_in);
    assign w0_d     = rk_q[127:96] ^ kt_q ^ {rcon_q, 24'h0};
    assign w1_d     = rk_q[95:64] ^ w0_d;
    assign w2_d     = rk_q[63:32] ^ w1_d;
    assign w3_d     = rk_q[31:0] ^ w2_d;
    assign rk_d     = {w0_d, w1_d, w2_d, w3_d};
    assign sr_d     = shift_rows(st_q);
    assign st_mix_d = ((rnd_q == 4'd10) ? sr_d :
                       {mix_col(sr_d[127:96]), mix_col(sr_d[95:64]),
                        mix_col(sr_d[63:32]), mix_col(sr_d[31:0])}) ^ rk_d;

    always_ff @(posedge HCLK or posedge HRESETn) begin
        if (HRESETn) begin
            cstate_q <= C_IDLE;
            st_q     <= '0;
            rk_q     <= '0;
            op_key_q <= '0;
            op_pt_q  <= '0;
            kt_q     <= '0;
            rcon_q   <= 8'h01;
            cnt_q    <= '0;
            rnd_q    <= '0;
        end else if (core_abort) begin
            cstate_q <= C_IDLE;
        end else if (core_go) begin
            op_key_q <= go_key;
            op_pt_q  <= go_pt;
            cnt_q    <= '0;
            cstate_q <= C_LOAD;
        end else begin
            case (cstate_q)
                C_IDLE: ;
                C_LOAD: begin
                    st_q     <= {st_q[119:0], op_pt_q[127:120] ^ op_key_q[127:120]};
                    rk_q     <= {rk_q[119:0], op_key_q[127:120]};
                    op_pt_q  <= {op_pt_q[119:0], 8'h00};
                    op_key_q <= {op_key_q[119:0], 8'h00};
                    cnt_q    <= cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        rnd_q    <= 4'd1;
                        rcon_q   <= 8'h01;
                        cstate_q <= C_SUB;
                    end
                end
                C_SUB: begin
                    st_q  <= {st_q[119:0], sbox_out};
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == 4'd15) cstate_q <= C_KEY;
                end
                C_KEY: begin
                    kt_q  <= {kt_q[23:0], sbox_out};
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == 4'd3) begin
                        cnt_q    <= '0;
                        cstate_q <= C_MIX;
                    end
                end
                C_MIX: begin
                    st_q     <= st_mix_d;
                    rk_q     <= rk_d;
                    rcon_q   <= xtime(rcon_q);
                    rnd_q    <= rnd_q + 4'd1;
                    cstate_q <= (rnd_q == 4'd10) ? C_OUT : C_SUB;
                end
                C_OUT:   cstate_q <= C_IDLE;
                default: cstate_q <= C_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_ip_top.sv
// Bench for aes_ip_top: AHB register traffic, FIPS-197 vectors, random vectors against
// a behavioural AES-128 model, BIST signature (when AES_BIST_EN is defined) and reset abort.
module tb_aes_ip_top;

  localparam logic [31:0] A_CTRL0 = 32'h00;
  localparam logic [31:0] A_CTRL1 = 32'h04;
  localparam logic [31:0] A_STAT0 = 32'h08;
  localparam logic [31:0] A_UNMAP = 32'h0C;
  localparam logic [31:0] A_KEY0  = 32'h10;
  localparam logic [31:0] A_PT0   = 32'h20;
  localparam logic [31:0] A_CT0   = 32'h30;
  localparam int BIST_N = 16;
  localparam logic [127:0] SEED = 128'h0123456789ABCDEF_FEDCBA9876543210;

  logic        HCLK, HRESETn, HSEL, HWRITE, HREADY, HREADYOUT, HRESP;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE, HBURST;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  sbox_t[256];

  aes_ip_top dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA), .HREADY(HREADY),
    .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP)
  );

  // clock / reset
  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic apply_reset();
    @(negedge HCLK);
    HRESETn = 1'b1;
    repeat (3) @(negedge HCLK);
    HRESETn = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // behavioural AES-128 model
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    while (y != 8'h00) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, b, c63;
    c63 = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        b[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c63[i];
      sbox_t[x] = b;
    end
  endtask

  function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
    logic [31:0] w[44];
    logic [7:0]  s[16];
    logic [7:0]  t[16];
    logic [7:0]  rc, a0, a1, a2, a3;
    logic [31:0] tmp, rkw;
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]], sbox_t[tmp[31:24]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) begin
      rkw = w[i/4];
      s[i] = pt[127-8*i -: 8] ^ rkw[31-8*(i%4) -: 8];
    end
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox_t[s[(i%4) + 4*(((i/4) + (i%4)) % 4)]];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (r < 10) begin
          t[4*c]   = gmul(8'h02, a0) ^ gmul(8'h03, a1) ^ a2 ^ a3;
          t[4*c+1] = a0 ^ gmul(8'h02, a1) ^ gmul(8'h03, a2) ^ a3;
          t[4*c+2] = a0 ^ a1 ^ gmul(8'h02, a2) ^ gmul(8'h03, a3);
          t[4*c+3] = gmul(8'h03, a0) ^ a1 ^ a2 ^ gmul(8'h02, a3);
        end
        rkw = w[4*r + c];
        for (int k = 0; k < 4; k++) s[4*c+k] = t[4*c+k] ^ rkw[31-8*k -: 8];
      end
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // driver tasks
  task automatic ahb_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge HCLK);
    HSEL = 1'b1; HADDR = a; HTRANS = 2'b10; HWRITE = 1'b1;
    @(negedge HCLK);
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
    @(negedge HCLK);
  endtask

  task automatic ahb_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge HCLK);
    HSEL = 1'b1; HADDR = a; HTRANS = 2'b10; HWRITE = 1'b0;
    @(negedge HCLK);
    HSEL = 1'b0; HTRANS = 2'b00;
    d = HRDATA;
  endtask

  task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    ahb_read(a, d);
    check(tag, d, exp);
  endtask

  task automatic load_operands(input logic [127:0] key, input logic [127:0] pt);
    ahb_write(A_CTRL0, 32'h1);
    for (int i = 0; i < 4; i++) ahb_write(A_KEY0 + 32'(4*i), key[32*i +: 32]);
    for (int i = 0; i < 4; i++) ahb_write(A_PT0 + 32'(4*i), pt[32*i +: 32]);
  endtask

  task automatic wait_done(input string tag, input int budget);
    logic [31:0] st;
    int cyc;
    st = 32'h0; cyc = 0;
    while (!st[0] && cyc < budget) begin
      ahb_read(A_STAT0, st);
      cyc += 2;
    end
    check({tag, "_done"}, {31'h0, st[0]}, 32'h1);
  endtask

  task automatic check_ct(input string tag);
    logic [31:0] d;
    for (int i = 0; i < 4; i++) begin
      ahb_read(A_CT0 + 32'(4*i), d);
      check($sformatf("%s_ct%0d", tag, i), d, exp_q.pop_front());
    end
  endtask

  task automatic push_exp(input logic [127:0] v);
    for (int i = 0; i < 4; i++) exp_q.push_back(v[32*i +: 32]);
  endtask

  task automatic run_vector(input string tag, input logic [127:0] key, input logic [127:0] pt,
                            input logic [127:0] exp);
    push_exp(exp);
    load_operands(key, pt);
    read_check({tag, "_busy"}, A_STAT0, 32'h2);
    wait_done(tag, 512);
    check_ct(tag);
  endtask

  localparam logic [127:0] K1 = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] P1 = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] C1 = 128'h69C4E0D86A7B0430D8CDB78070B4C55A;
  localparam logic [127:0] K2 = 128'h2B7E151628AED2A6ABF7158809CF4F3C;
  localparam logic [127:0] P2 = 128'h6BC1BEE22E409F96E93D7E117393172A;
  localparam logic [127:0] C2 = 128'h3AD77BB40D7A3660A89ECAF32466EF97;

  initial begin
    logic [127:0] rk, rp, lfsr, misr, k2b;
    logic [31:0] d, last_rd;
    HRESETn = 1'b1; HSEL = 1'b0; HADDR = '0; HTRANS = 2'b00; HWRITE = 1'b0;
    HSIZE = 3'b010; HBURST = 3'b000; HWDATA = '0; HREADY = 1'b1;
    build_sbox();
    repeat (3) @(negedge HCLK);
    HRESETn = 1'b0;

    // reset state
    check("hrdata_rst", HRDATA, 32'h0);
    check("hreadyout", {31'h0, HREADYOUT}, 32'h1);
    check("hresp", {31'h0, HRESP}, 32'h0);
    read_check("stat0_rst", A_STAT0, 32'h0);
    read_check("ctrl0_rst", A_CTRL0, 32'h0);
    push_exp(128'h0);
    check_ct("rst");

    // register access
    ahb_write(A_KEY0, 32'h0C0D0E0F);
    read_check("key0_rb", A_KEY0, 32'h0C0D0E0F);
    ahb_write(A_CT0, 32'hFFFFFFFF);
    read_check("ct0_ro", A_CT0, 32'h0);
    ahb_write(A_UNMAP, 32'hA5A5A5A5);
    ahb_read(A_UNMAP, last_rd);
    check("unmapped", last_rd, 32'h0);
    ahb_read(A_KEY0, last_rd);
    ahb_write(A_PT0, 32'h12345678);
    check("hrdata_hold", HRDATA, last_rd);

    // FIPS-197 vectors
    run_vector("fips", K1, P1, C1);
    ahb_write(A_CTRL0, 32'h1);
    read_check("done_clr", A_STAT0, 32'h0);
    read_check("ctrl0_pend", A_CTRL0, 32'h1);
    run_vector("sp800", K2, P2, C2);

    // PT3 write without a pending start only stores data
    ahb_write(A_PT0 + 32'hC, 32'hDEADBEEF);
    read_check("pt3_nostart_stat", A_STAT0, 32'h1);
    read_check("pt3_rb", A_PT0 + 32'hC, 32'hDEADBEEF);

    // random vectors against the model
    for (int n = 0; n < 4; n++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      rp = {$urandom, $urandom, $urandom, $urandom};
      run_vector($sformatf("rnd%0d", n), rk, rp, aes_enc(rk, rp));
    end

    // operands are latched at launch; KEY writes while busy do not disturb the run
    rk = {$urandom, $urandom, $urandom, $urandom};
    rp = {$urandom, $urandom, $urandom, $urandom};
    push_exp(aes_enc(rk, rp));
    load_operands(rk, rp);
    k2b = ~rk;
    ahb_write(A_KEY0, k2b[31:0]);
    read_check("busy_keywr", A_STAT0, 32'h2);
    wait_done("latch", 512);
    check_ct("latch");
    read_check("key0_new", A_KEY0, k2b[31:0]);

`ifdef AES_BIST_EN
    lfsr = SEED; misr = '0;
    for (int n = 0; n < BIST_N; n++) begin
      misr = {misr[126:0], misr[127]} ^ aes_enc(lfsr, {lfsr[63:0], lfsr[127:64]});
      lfsr = {lfsr[126:0], lfsr[127] ^ lfsr[6] ^ lfsr[1] ^ lfsr[0]};
    end
    for (int run = 0; run < 2; run++) begin
      push_exp(misr);
      ahb_write(A_CTRL1, 32'h1);
      read_check($sformatf("bist%0d_busy", run), A_STAT0, 32'h2);
      ahb_write(A_CTRL0, 32'h1);
      read_check($sformatf("bist%0d_ctrl0_ign", run), A_CTRL0, 32'h0);
      wait_done($sformatf("bist%0d", run), BIST_N * 512);
      check_ct($sformatf("bist%0d", run));
      ahb_write(A_CTRL1, 32'h0);
    end
    ahb_write(A_CTRL1, 32'h1);
    repeat (100) @(negedge HCLK);
    ahb_write(A_CTRL1, 32'h0);
    read_check("bist_abort", A_STAT0, 32'h0);
    read_check("ctrl1_clr", A_CTRL1, 32'h0);
    run_vector("post_bist", K1, P1, C1);
`else
    ahb_write(A_CTRL1, 32'h1);
    read_check("ctrl1_absent", A_CTRL1, 32'h0);
    read_check("ctrl1_nobusy", A_STAT0, 32'h1);
    push_exp(aes_enc(rk, rp));
    check_ct("ct_kept");
`endif

    // reset in the middle of an encryption
    load_operands(K2, P2);
    repeat (50) @(negedge HCLK);
    apply_reset();
    read_check("midrst_stat", A_STAT0, 32'h0);
    read_check("midrst_ctrl0", A_CTRL0, 32'h0);
    push_exp(128'h0);
    check_ct("midrst");
    run_vector("after_rst", K1, P1, C1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/aes_ip_top.md
Name: aes_ip_top

Overview:
- AHB-Lite slave peripheral wrapping an iterative AES-128 encryption core with an 8-bit (byte-serial) datapath.
- Software programs the 128-bit key and plaintext through 32-bit registers, arms a start, polls status, then reads the 128-bit ciphertext.
- A built-in self-test (BIST) mode runs pseudo-random encryptions and compresses the results into a MISR signature, readable in the CT registers.

Parameters:
- BIST_COUNT, 16, number of encryptions per BIST run.
- LFSR_SEED, 128'h0123456789ABCDEF_FEDCBA9876543210, BIST key/plaintext LFSR seed.

Ports:
- HCLK input 1 clock; all logic on rising edge.
- HRESETn input 1 reset.
- HSEL input 1 slave select.
- HADDR input 32 byte address; only [5:2] decoded.
- HTRANS input 2 transfer type; NONSEQ/SEQ (bit1=1) valid.
- HWRITE input 1 1=write.
- HSIZE input 3 ignored; all accesses treated as 32-bit.
- HBURST input 3 ignored.
- HWDATA input 32 write data, sampled in data phase.
- HREADY input 1 bus ready; address phase accepted only when 1.
- HRDATA output 32 read data.
- HREADYOUT output 1 constant 1 (zero wait states).
- HRESP output 1 constant 0 (OKAY).

Behaviour:
- Clock HCLK. Reset HRESETn, asynchronous, active-high. In reset, all registers clear, HRDATA=0, core idle, MISR/LFSR reload.
- Address phase is valid when HSEL & HREADY & HTRANS[1]. The slave latches address and direction in that phase.
- Write: the next cycle (data phase) stores HWDATA into the latched register. This happens even if HSEL has dropped.
- Read: HRDATA is registered at the address-phase edge and holds its value until the next read.
- Register map:
  - 0x00 CTRL0 (RW): bit0 start. Writing 1 sets start_pending and clears done; reads return start_pending.
  - 0x04 CTRL1 (RW): bit0 bist_en. A 0→1 transition clears done and MISR and launches a BIST run.
  - 0x08 STAT0 (RO): bit0 done (sticky), bit1 busy.
  - 0x10–0x1C KEY0..3 (RW): KEY0=key[31:0] … KEY3=key[127:96].
  - 0x20–0x2C PT0..3 (RW): same word ordering as KEY.
  - 0x30–0x3C CT0..3 (RO): CT0=ct[31:0] … CT3=ct[127:96].
  - Unmapped reads return 0; unmapped writes and writes to RO registers are ignored.
- Byte order: FIPS-197. key[127:120] is state byte 0.
- Normal launch:
  - A write to PT3 while start_pending=1, busy=0, bist_en=0 launches an encryption the cycle after the data phase.
  - On launch: start_pending←0, busy←1, done←0.
  - PT3 write without start_pending only stores data.
  - KEY/PT writes while busy update the registers only; the core uses operands latched at launch.
- Core FSM:
  - States IDLE → LOAD (16 cycles, byte shift-in) → ROUND ×10 (SubBytes via single S-box, ShiftRows, MixColumns skipped in round 10, AddRoundKey, on-the-fly key expansion) → OUT.
  - Total latency is fixed and ≤512 cycles.
  - In OUT: ct register ← result, busy←0, done←1.
- BIST:
  - Runs BIST_COUNT encryptions with key/PT from a 128-bit LFSR (x^128+x^7+x^2+x+1), stepped once per encryption.
  - Each ciphertext is XOR-folded into a 128-bit MISR.
  - At the end, CT registers ← MISR, busy←0, done←1.
  - While bist_en=1, CTRL0 start and PT3 launches are ignored. Clearing bist_en mid-run aborts, with busy←0 and done unchanged.
- Simultaneous events: if the core sets done in the same cycle as a CTRL0 start write, the write wins (done=0).
- Reset mid-operation aborts immediately; all state returns to reset values.

Optional Feature:
- Macro AES_BIST_EN.
- Defined: BIST logic (LFSR, MISR, CTRL1 bit0) is present as described.
- Undefined: CTRL1 reads 0 and writes are ignored; no LFSR/MISR logic; the CT registers always hold the last normal ciphertext.

Test Plan:
- After reset: read STAT0→0x0, CT0..3→0, HREADYOUT=1, HRESP=0.
- Write KEY0=0x0C0D0E0F and read back; read CT0 after writing it → unchanged 0.
- Write CTRL0=1, KEY=000102030405060708090A0B0C0D0E0F, PT=00112233445566778899AABBCCDDEEFF (PT3 last). Poll STAT0.bit0=1 within 512 cycles → CT={CT3..CT0}=69C4E0D86A7B0430D8CDB78070B4C55A.
- Write CTRL0=1, KEY=2B7E151628AED2A6ABF7158809CF4F3C, PT=6BC1BEE22E409F96E93D7E117393172A → CT=3AD77BB40D7A3660A89ECAF32466EF97; done was cleared by the CTRL0 write.
- Write CTRL1=1: busy=1 until done=1 → CT0..3 equal the internal MISR and are deterministic across two runs. Then write CTRL1=0 → normal mode works.
- Assert reset during a normal encryption → STAT0=0, CT=0; a subsequent full sequence still yields the FIPS-197 vector.
